fsm_start_arbiter: RTL

- Shares the single design_fsm instance between REQ_N requesters.
- Grants requesters round-robin and issues the one-cycle start_fsm pulse on the owner's behalf.
- Tracks cs_fsm until the FSM leaves idle and then returns to it, then reports completion to the owner.
- Sits between the requesting test/control logic and design_fsm, and drives design_fsm's start_fsm input.

---
 rtl/fsm_arb_pkg.sv | 16 +
 rtl/rr_picker.sv | 30 +++
 rtl/fsm_start_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fsm_arb_pkg.sv
// Shared types and constants for the design_fsm start arbiter.
package fsm_arb_pkg;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t FSM_IDLE = 2'b00;

    typedef enum logic [2:0] {
        ARB,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        RELEASE
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_picker #(
    parameter int unsigned REQ_N = 4,
    parameter int unsigned IDX_W = $clog2(REQ_N)
) (
    input  logic [REQ_N-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [REQ_N-1:0] pick,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < REQ_N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % REQ_N);
            if (!found && req[cand]) begin
                found      = 1'b1;
                pick[cand] = 1'b1;
                idx        = cand;
            end
        end
    end

endmodule

// File: rtl/fsm_start_arbiter.sv
// Round-robin owner of the single design_fsm: pulses start_fsm, tracks cs_fsm through
// one busy period and reports completion (or timeout) to the granted requester.
module fsm_start_arbiter
    import fsm_arb_pkg::*;
#(
    parameter int unsigned REQ_N   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [REQ_N-1:0]         req,
    output logic [REQ_N-1:0]         gnt,
    output logic [REQ_N-1:0]         done,
    output logic [$clog2(REQ_N)-1:0] owner,
    output logic                     busy,
    output logic                     start_fsm,
    input  fsm_state_t               cs_fsm,
    input  logic                     clr_err,
    output logic                     timeout_err
);

    localparam int unsigned IDX_W = $clog2(REQ_N);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [REQ_N-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout_hit;

    logic [REQ_N-1:0] pick;
    logic [IDX_W-1:0] pick_idx;

    rr_picker #(
        .REQ_N (REQ_N),
        .IDX_W (IDX_W)
    ) u_picker (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick),
        .idx  (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            owner_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        timeout_hit = 1'b0;

        unique case (state_q)
            ARB: begin
                if (|req) begin
                    owner_d = pick_idx;
                    sel_d   = pick;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (cs_fsm != FSM_IDLE) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = RELEASE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (cs_fsm == FSM_IDLE) begin
                    state_d = RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = RELEASE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                ptr_d   = (owner_q == IDX_W'(REQ_N - 1)) ? '0 : owner_q + IDX_W'(1);
                state_d = ARB;
            end
            default: state_d = ARB;
        endcase

        // A timeout on the same edge as clr_err must stay visible.
        if (timeout_hit) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Outputs decode straight from state so an async reset drops them immediately.
    always_comb begin
        gnt         = (state_q == START || state_q == WAIT_BUSY || state_q == WAIT_DONE) ?
                      sel_q : '0;
        done        = (state_q == RELEASE) ? sel_q : '0;
        start_fsm   = (state_q == START);
        busy        = (state_q != ARB);
        owner       = owner_q;
        timeout_err = err_q;
    end

endmodule
